// File: rtl/branch_bypass_ctrl_if.sv
// Decode-side bundle for branch_bypass_ctrl: decode fields and flush in,
// load-use stall and registered X-stage bypass selects out.
interface branch_bypass_ctrl_if #(
    parameter int unsigned REG_AW = 5
) ();
    logic              d_valid;
    logic [REG_AW-1:0] d_rs1;
    logic [REG_AW-1:0] d_rs2;
    logic              d_use_rs1;
    logic              d_use_rs2;
    logic [REG_AW-1:0] d_rd;
    logic              d_wen;
    logic              d_load;
    logic              flush;
    logic              d_stall;
    logic [1:0]        bypass_sel_rs1;
    logic [1:0]        bypass_sel_rs2;

    modport master (
        output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wen, d_load, flush,
        input  d_stall, bypass_sel_rs1, bypass_sel_rs2
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_wen, d_load, flush,
        output d_stall, bypass_sel_rs1, bypass_sel_rs2
    );
endinterface

// File: rtl/branch_bypass_ctrl.sv
// Bypass/hazard controller for the X-stage branch comparator: registered MX/WX
// operand selects and a one-cycle load-use stall. BYPASS_PERF_CNT_EN adds stall_count.
module branch_bypass_ctrl #(
    parameter int unsigned REG_AW = 5
`ifdef BYPASS_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_bypass_ctrl_if.slave  bus
`ifdef BYPASS_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_count
`endif
);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_MX = 2'b01;
    localparam logic [1:0] SEL_WX = 2'b10;

    // X and M stage producer entries; the W entry is never consulted because
    // the regfile writes before it is read.
    logic              r_x_valid;
    logic [REG_AW-1:0] r_x_rd;
    logic              r_x_wen;
    logic              r_x_load;
    logic              r_m_valid;
    logic [REG_AW-1:0] r_m_rd;
    logic              r_m_wen;
    logic [1:0]        r_sel_rs1;
    logic [1:0]        r_sel_rs2;

    logic       w_x_hit_rs1;
    logic       w_x_hit_rs2;
    logic       w_m_hit_rs1;
    logic       w_m_hit_rs2;
    logic       w_load_use;
    logic       w_bubble;
    logic [1:0] w_sel_rs1;
    logic [1:0] w_sel_rs2;

    function automatic logic f_match(input logic              valid,
                                     input logic              wen,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return valid & wen & (rd != '0) & (rd == rs);
    endfunction

    assign w_x_hit_rs1 = bus.d_use_rs1 & f_match(r_x_valid, r_x_wen, r_x_rd, bus.d_rs1);
    assign w_x_hit_rs2 = bus.d_use_rs2 & f_match(r_x_valid, r_x_wen, r_x_rd, bus.d_rs2);
    assign w_m_hit_rs1 = bus.d_use_rs1 & f_match(r_m_valid, r_m_wen, r_m_rd, bus.d_rs1);
    assign w_m_hit_rs2 = bus.d_use_rs2 & f_match(r_m_valid, r_m_wen, r_m_rd, bus.d_rs2);

    // A load in X cannot feed MX; the consumer waits one cycle and picks it up via WX.
    assign w_load_use = bus.d_valid & ~bus.flush & r_x_load & (w_x_hit_rs1 | w_x_hit_rs2);
    assign w_bubble   = bus.flush | w_load_use | ~bus.d_valid;

    // Youngest producer wins: MX ahead of WX.
    always_comb begin
        w_sel_rs1 = SEL_RF;
        w_sel_rs2 = SEL_RF;
        if (w_x_hit_rs1)      w_sel_rs1 = SEL_MX;
        else if (w_m_hit_rs1) w_sel_rs1 = SEL_WX;
        if (w_x_hit_rs2)      w_sel_rs2 = SEL_MX;
        else if (w_m_hit_rs2) w_sel_rs2 = SEL_WX;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_valid <= 1'b0;
            r_x_rd    <= '0;
            r_x_wen   <= 1'b0;
            r_x_load  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_rd    <= '0;
            r_m_wen   <= 1'b0;
            r_sel_rs1 <= SEL_RF;
            r_sel_rs2 <= SEL_RF;
        end else begin
            r_m_valid <= r_x_valid;
            r_m_rd    <= r_x_rd;
            r_m_wen   <= r_x_wen;
            if (w_bubble) begin
                r_x_valid <= 1'b0;
                r_x_rd    <= '0;
                r_x_wen   <= 1'b0;
                r_x_load  <= 1'b0;
                r_sel_rs1 <= SEL_RF;
                r_sel_rs2 <= SEL_RF;
            end else begin
                r_x_valid <= 1'b1;
                r_x_rd    <= bus.d_rd;
                r_x_wen   <= bus.d_wen;
                r_x_load  <= bus.d_load;
                r_sel_rs1 <= w_sel_rs1;
                r_sel_rs2 <= w_sel_rs2;
            end
        end
    end

    assign bus.d_stall        = w_load_use & rst_n;
    assign bus.bypass_sel_rs1 = r_sel_rs1;
    assign bus.bypass_sel_rs2 = r_sel_rs2;

`ifdef BYPASS_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_load_use && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_branch_bypass_ctrl.sv
// Scoreboard bench for branch_bypass_ctrl: expected selects are queued as each
// decode slot is driven and compared one cycle later when the instruction sits in X.
module tb_branch_bypass_ctrl;

    localparam int unsigned REG_AW = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [3:0] exp_q[$];

    branch_bypass_ctrl_if #(.REG_AW(REG_AW)) bus ();

`ifdef BYPASS_PERF_CNT_EN
    logic [31:0] stall_count;
    branch_bypass_ctrl #(.REG_AW(REG_AW), .CNT_W(32)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stall_count (stall_count)
    );
`else
    branch_bypass_ctrl #(.REG_AW(REG_AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // One decode slot: check d_stall now, queue selects expected once this slot reaches X.
    task automatic slot(input string tag,
                        input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic fl,
                        input logic exp_stall, input logic [1:0] exp_s1, input logic [1:0] exp_s2);
        logic [3:0] e;
        bus.d_valid   = v;
        bus.d_rs1     = rs1;
        bus.d_rs2     = rs2;
        bus.d_use_rs1 = u1;
        bus.d_use_rs2 = u2;
        bus.d_rd      = rd;
        bus.d_wen     = wen;
        bus.d_load    = ld;
        bus.flush     = fl;
        #1;
        check({tag, ".stall"}, 32'(bus.d_stall), 32'(exp_stall));
        exp_q.push_back({exp_s1, exp_s2});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".sel1"}, 32'(bus.bypass_sel_rs1), 32'(e[3:2]));
        check({tag, ".sel2"}, 32'(bus.bypass_sel_rs2), 32'(e[1:0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            slot("idle", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        // Reset: a would-be stall pattern must still read 0 while rst_n=0.
        slot("rst", 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;
        idle(2);

        // add x5 ; beq x5,x6 -> MX on rs1
        slot("add5",    1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("beq5_6",  1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        idle(2);

        // add x5 ; nop ; beq x6,x5 -> WX on rs2
        slot("add5b",   1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(1);
        slot("beq6_5",  1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        idle(2);

        // lw x7 ; beq x7,x7 -> one stall with bubble, then WX on both
        slot("lw7",     1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("beq77s",  1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        slot("beq77",   1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
        idle(2);

        // add x5 ; add x5 ; beq x5,x0 -> youngest wins, x0 never bypasses
        slot("add5c",   1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("add5d",   1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("beq5_0",  1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        slot("add0",    1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("beq0_0",  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(2);

        // Unused source operand does not create a load-use hazard
        slot("lw7b",    1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("nouse7",  1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(2);

        // lw x7 ; dependent flushed in D -> no stall, bubble, then WX for the next instruction
        slot("lw7c",    1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("flush7",  1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        slot("after_fl",1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        idle(2);

        // Clean counter start, three load-use stalls, then reset mid-stream
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        slot("lw7d",    1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("st1",     1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        slot("rt1",     1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        slot("lw8",     1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("st2",     1'b1, 5'd2, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        slot("rt2",     1'b1, 5'd2, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        slot("lw9",     1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        slot("st3",     1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
`ifdef BYPASS_PERF_CNT_EN
        check("cnt3", stall_count, 32'd3);
`endif
        // lw x9 now in M: reset must drop the pending WX select
        rst_n = 1'b0;
        slot("rst_mid", 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
`ifdef BYPASS_PERF_CNT_EN
        check("cnt_rst", stall_count, 32'd0);
`endif
        rst_n = 1'b1;
        slot("post_rst",1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
